md5_core_scheduler: RTL and testbench
=====================================

MD5_CORE_SCHEDULER -- requirements
Module: md5_core_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of MD5 hash cores scheduled (2..16).
REQ-002 SHALL have parameter TAG_W, default 32, width of the candidate-string tag/index.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_CORES), width of a core index.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain, all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  level; 1 = run, dispatch candidates; 0 = stop after in-flight work.
REQ-007 SHALL have port clear  input  1  one-cycle pulse; releases the FOUND state.
REQ-008 SHALL have port in_valid  input  1  candidate available from the string feeder.
REQ-009 SHALL have port in_tag  input  TAG_W  candidate tag, qualified by in_valid.
REQ-010 SHALL have port in_ready  output  1  scheduler accepts the candidate this cycle.
REQ-011 SHALL have port core_start  output  NUM_CORES  one-hot, one-cycle start pulse per core.
REQ-012 SHALL have port core_tag  output  TAG_W  tag broadcast to the cores, valid while any core_start bit is 1.
REQ-013 SHALL have port core_done  input  NUM_CORES  per-core one-cycle completion pulse.
REQ-014 SHALL have port core_match  input  NUM_CORES  per-core hash-match flag, qualified by the same bit of core_done.
REQ-015 SHALL have port match_valid  output  1  a match has been captured; held until clear.
REQ-016 SHALL have port match_tag  output  TAG_W  tag of the matching candidate.
REQ-017 SHALL have port match_core  output  IDX_W  index of the matching core.
REQ-018 SHALL have port idle  output  1  1 when the FSM is in IDLE.
REQ-019 SHALL have port issued_count  output  32  number of candidates dispatched since reset.
REQ-020 SHALL have port done_count  output  32  number of core_done pulses counted since reset.

Function
REQ-021 SHALL implement the FSM states IDLE, RUN, DRAIN and FOUND.
REQ-022 SHALL use these transitions: IDLE->RUN when enable=1; RUN->DRAIN when enable=0 or a match is captured; DRAIN->IDLE when all cores are free and no match is captured; DRAIN->FOUND when all cores are free and a match is captured; FOUND->IDLE on clear.
REQ-023 SHALL keep a per-core occupied bit, set on the clock edge on which that core is granted and cleared on the clock edge following its core_done pulse.
REQ-024 SHALL drive in_ready combinationally as (state==RUN) AND (at least one core is unoccupied) AND (no match captured).
REQ-025 SHALL perform an accept when in_valid=1 and in_ready=1, and SHALL grant the accept to the first unoccupied core in round-robin order, searching from index (last_grant+1) mod NUM_CORES.
REQ-026 SHALL, for an accept in cycle N, register core_start[granted]=1 and core_tag=in_tag for cycle N+1 only; core_start SHALL be 0 in all other cycles.
REQ-027 SHALL store the accepted tag in a per-core tag register so the tag can be reported on a match.
REQ-028 SHALL allow a core that pulses core_done in cycle N to be granted again no earlier than cycle N+1.
REQ-029 SHALL capture a match in cycle N when core_done[k]=1 and core_match[k]=1, setting match_valid=1, match_tag=tag register of core k and match_core=k at cycle N+1.
REQ-030 SHALL, when several matching core_done pulses occur in the same cycle, capture the lowest-index matching core.
REQ-031 SHALL ignore all later matches until clear.
REQ-032 SHALL ignore a core_done pulse for a core that is not occupied, with no effect on occupancy or match capture, while still counting it in done_count.
REQ-033 SHALL ignore core_match when the corresponding core_done bit is 0.
REQ-034 SHALL increment issued_count on each accept, wrapping modulo 2^32.
REQ-035 SHALL increment done_count by the number of core_done bits set in the cycle, wrapping modulo 2^32.
REQ-036 SHALL give a capture in the same cycle as an accept priority for in_ready in the following cycle only; the candidate already accepted in that cycle SHALL still be started.
REQ-037 SHALL treat clear outside FOUND as a no-op.
REQ-038 SHALL give reset priority over clear when both are active in the same cycle.

Reset
REQ-039 SHALL, while reset_n=0 at a clock edge, force: state=IDLE, every occupied bit=0, last_grant=NUM_CORES-1, core_start=0, core_tag=0, match_valid=0, match_tag=0, match_core=0, issued_count=0, done_count=0, idle=1.
REQ-040 SHALL give reset priority over all other inputs, and SHALL abandon in-flight work if reset is applied mid-RUN, with no start pulse issued in the cycle after reset.

Verification
REQ-041 SHALL be covered by a directed bench for round-robin dispatch: NUM_CORES=4, enable=1, in_valid held with tags 0..7, cores complete after 10 cycles with no match -> start order core 0,1,2,3, then stall, then 0,1,2,3; issued_count=8; done_count=8.
REQ-042 SHALL be covered by a directed bench for first-match capture: core 2 pulses done with match=1 for tag 0x0000_0006 -> match_valid=1 next cycle, match_tag=6, match_core=2; in_ready=0; FSM reaches FOUND after the other cores finish.
REQ-043 SHALL be covered by a directed bench for a simultaneous match: cores 1 and 3 pulse done with match=1 in the same cycle -> match_core=1; the later match from core 0 is ignored.
REQ-044 SHALL be covered by a directed bench for stop-and-drain: enable dropped while 3 cores are occupied -> no new start pulses; idle=1 one cycle after the last core_done; match_valid=0.
REQ-045 SHALL be covered by a directed bench for stray done and counter wrap: core_done pulsed on an unoccupied core -> occupancy unchanged and done_count incremented; issued_count forced to 0xFFFF_FFFF then one accept -> issued_count=0.
REQ-046 SHALL be covered by a directed bench for reset mid-run: reset_n=0 for 1 cycle while cores are occupied -> all outputs at reset values next cycle; the first grant after reset goes to core 0.

Source files
------------

// File: rtl/md5_core_scheduler.sv
// Dispatches candidate tags round-robin across NUM_CORES MD5 cores, tracks core
// occupancy, captures the first hash match and keeps dispatch/completion counters.
module md5_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int TAG_W     = 32,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 in_ready,
  output logic [NUM_CORES-1:0] core_start,
  output logic [TAG_W-1:0]     core_tag,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_match,
  output logic                 match_valid,
  output logic [TAG_W-1:0]     match_tag,
  output logic [IDX_W-1:0]     match_core,
  output logic                 idle,
  output logic [31:0]          issued_count,
  output logic [31:0]          done_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FOUND} state_t;

  state_t               state_r, state_s;
  logic [NUM_CORES-1:0] occ_r, occ_s;
  logic [TAG_W-1:0]     tag_r [NUM_CORES];
  logic [IDX_W-1:0]     last_grant_r;
  logic [IDX_W-1:0]     grant_idx_s, cand_s, cap_idx_s;
  logic [NUM_CORES-1:0] grant_onehot_s, hit_s;
  logic                 cap_found_s, capture_s, accept_s, all_free_s, in_ready_s;
  logic [NUM_CORES-1:0] core_start_r;
  logic [TAG_W-1:0]     core_tag_r, match_tag_r;
  logic                 match_valid_r;
  logic [IDX_W-1:0]     match_core_r;
  logic [31:0]          issued_r, done_r;

  function automatic logic [31:0] count_ones(input logic [NUM_CORES-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // Round-robin grant: scan backwards so the first free core after last_grant wins.
  always_comb begin
    grant_idx_s = '0;
    cand_s      = '0;
    for (int i = NUM_CORES; i >= 1; i--) begin
      cand_s = IDX_W'((int'(last_grant_r) + i) % NUM_CORES);
      if (!occ_r[cand_s]) begin
        grant_idx_s = cand_s;
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Lowest-index matching core among occupied cores that finished this cycle.
  always_comb begin
    hit_s       = core_done & core_match & occ_r;
    cap_idx_s   = '0;
    cap_found_s = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        cap_idx_s   = IDX_W'(i);
        cap_found_s = 1'b1;
      end else begin
        cap_idx_s   = cap_idx_s;
      end
    end
  end

  // Handshake, occupancy update and grant decode.
  always_comb begin
    in_ready_s     = (state_r == ST_RUN) && (occ_r != {NUM_CORES{1'b1}}) && !match_valid_r;
    accept_s       = in_valid && in_ready_s;
    capture_s      = cap_found_s && !match_valid_r;
    all_free_s     = ((occ_r & ~core_done) == {NUM_CORES{1'b0}});
    grant_onehot_s = {NUM_CORES{1'b0}};
    if (accept_s) begin
      grant_onehot_s = {{(NUM_CORES-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      grant_onehot_s = {NUM_CORES{1'b0}};
    end
    occ_s = (occ_r & ~core_done) | grant_onehot_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_s = ST_RUN;
        else        state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable || match_valid_r || capture_s) state_s = ST_DRAIN;
        else                                       state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (all_free_s) state_s = (match_valid_r || capture_s) ? ST_FOUND : ST_IDLE;
        else            state_s = ST_DRAIN;
      end
      ST_FOUND: begin
        if (clear) state_s = ST_IDLE;
        else       state_s = ST_FOUND;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, occupancy, per-core tags, start pulses, match capture and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      occ_r         <= {NUM_CORES{1'b0}};
      last_grant_r  <= IDX_W'(NUM_CORES - 1);
      core_start_r  <= {NUM_CORES{1'b0}};
      core_tag_r    <= {TAG_W{1'b0}};
      match_valid_r <= 1'b0;
      match_tag_r   <= {TAG_W{1'b0}};
      match_core_r  <= {IDX_W{1'b0}};
      issued_r      <= 32'd0;
      done_r        <= 32'd0;
      for (int i = 0; i < NUM_CORES; i++) begin
        tag_r[i] <= {TAG_W{1'b0}};
      end
    end else begin
      state_r      <= state_s;
      occ_r        <= occ_s;
      core_start_r <= grant_onehot_s;
      done_r       <= done_r + count_ones(core_done);
      if (accept_s) begin
        core_tag_r           <= in_tag;
        tag_r[grant_idx_s]   <= in_tag;
        last_grant_r         <= grant_idx_s;
        issued_r             <= issued_r + 32'd1;
      end else begin
        core_tag_r   <= core_tag_r;
        last_grant_r <= last_grant_r;
        issued_r     <= issued_r;
      end
      // Only the first match is kept; clear releases it solely from FOUND.
      if (capture_s) begin
        match_valid_r <= 1'b1;
        match_tag_r   <= tag_r[cap_idx_s];
        match_core_r  <= cap_idx_s;
      end else if ((state_r == ST_FOUND) && clear) begin
        match_valid_r <= 1'b0;
      end else begin
        match_valid_r <= match_valid_r;
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign core_start   = core_start_r;
  assign core_tag     = core_tag_r;
  assign match_valid  = match_valid_r;
  assign match_tag    = match_tag_r;
  assign match_core   = match_core_r;
  assign idle         = (state_r == ST_IDLE);
  assign issued_count = issued_r;
  assign done_count   = done_r;

endmodule

// File: tb/tb_md5_core_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a behavioural scheduler model.
module tb_md5_core_scheduler;
  localparam int N  = 4;
  localparam int TW = 32;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0, enable = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready;
  logic [N-1:0]  core_start, core_done = '0, core_match = '0;
  logic [TW-1:0] core_tag, match_tag;
  logic          match_valid, idle;
  logic [IW-1:0] match_core;
  logic [31:0]   issued_count, done_count;

  always #5 clk = ~clk;

  md5_core_scheduler #(.NUM_CORES(N), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
    .core_start(core_start), .core_tag(core_tag),
    .core_done(core_done), .core_match(core_match),
    .match_valid(match_valid), .match_tag(match_tag), .match_core(match_core),
    .idle(idle), .issued_count(issued_count), .done_count(done_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the scheduler
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_FOUND} mphase_t;
  mphase_t       m_phase = M_IDLE;
  bit            m_busy [N];
  logic [TW-1:0] m_tag [N];
  int            m_last = N - 1;
  logic [N-1:0]  m_start = '0;
  logic [TW-1:0] m_core_tag = '0, m_mtag = '0;
  bit            m_mv = 1'b0;
  int            m_mcore = 0;
  logic [31:0]   m_issued = '0, m_done = '0;

  // Core emulation
  int            timer [N];
  bit            timer_match [N];
  bit            directed = 1'b1;
  bit            stray_en = 1'b0;
  int            lat_tab [N];
  bit            mt_tab [N];
  logic [N-1:0]  extra_done = '0, extra_match = '0;
  int            start_log [$];

  function automatic bit model_ready();
    bit any_free = 1'b0;
    for (int k = 0; k < N; k++) if (!m_busy[k]) any_free = 1'b1;
    return (m_phase == M_RUN) && any_free && !m_mv;
  endfunction

  task automatic arm_core(input int g);
    if (directed) begin
      timer[g] = lat_tab[g];
      timer_match[g] = mt_tab[g];
    end else begin
      timer[g] = $urandom_range(2, 15);
      timer_match[g] = ($urandom_range(0, 99) < 4);
    end
  endtask

  task automatic model_step();
    int g, cap_k;
    bit cap, all_free;
    mphase_t ph;
    if (!reset_n) begin
      m_phase = M_IDLE; m_last = N - 1; m_start = '0; m_core_tag = '0;
      m_mv = 1'b0; m_mtag = '0; m_mcore = 0; m_issued = '0; m_done = '0;
      for (int k = 0; k < N; k++) begin m_busy[k] = 1'b0; m_tag[k] = '0; timer[k] = 0; end
      return;
    end
    g = -1;
    if (in_valid && model_ready())
      for (int i = 1; i <= N; i++) if (g < 0 && !m_busy[(m_last + i) % N]) g = (m_last + i) % N;
    cap = 1'b0; cap_k = 0;
    for (int k = 0; k < N; k++)
      if (!cap && m_busy[k] && core_done[k] && core_match[k]) begin cap = 1'b1; cap_k = k; end
    all_free = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (core_done[k]) begin m_done = m_done + 32'd1; m_busy[k] = 1'b0; end
      if (m_busy[k]) all_free = 1'b0;
    end
    if (cap && !m_mv) begin m_mv = 1'b1; m_mtag = m_tag[cap_k]; m_mcore = cap_k; end
    ph = m_phase;
    case (ph)
      M_IDLE:  if (enable) m_phase = M_RUN;
      M_RUN:   if (!enable || m_mv) m_phase = M_DRAIN;
      M_DRAIN: if (all_free) m_phase = m_mv ? M_FOUND : M_IDLE;
      M_FOUND: if (clear) begin m_phase = M_IDLE; m_mv = 1'b0; end
      default: m_phase = M_IDLE;
    endcase
    m_start = '0;
    if (g >= 0) begin
      m_busy[g] = 1'b1; m_tag[g] = in_tag; m_core_tag = in_tag; m_last = g;
      m_issued = m_issued + 32'd1; m_start = N'(1) << g; arm_core(g);
    end
  endtask

  task automatic drive_cores();
    logic [N-1:0] d, m;
    d = extra_done;
    m = (N'($urandom) & ~extra_done) | (extra_match & extra_done);
    for (int k = 0; k < N; k++) begin
      if (timer[k] > 0) begin
        timer[k]--;
        if (timer[k] == 0) begin d[k] = 1'b1; m[k] = timer_match[k]; end
      end else if (stray_en && !m_busy[k] && !d[k] && $urandom_range(0, 39) == 0) begin
        d[k] = 1'b1;
      end
    end
    core_done = d;
    core_match = m;
  endtask

  task automatic step();
    @(negedge clk);
    drive_cores();
    #1;
    if (reset_n) check_eq("in_ready", in_ready, model_ready());
    model_step();
    @(posedge clk);
    #1;
    check_eq("core_start", core_start, m_start);
    if (m_start != '0) check_eq("core_tag", core_tag, m_core_tag);
    check_eq("match_valid", match_valid, m_mv);
    if (m_mv) begin
      check_eq("match_tag", match_tag, m_mtag);
      check_eq("match_core", match_core, m_mcore);
    end
    check_eq("idle", idle, m_phase == M_IDLE);
    check_eq("issued_count", issued_count, m_issued);
    check_eq("done_count", done_count, m_done);
    for (int k = 0; k < N; k++) if (core_start[k]) start_log.push_back(k);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic feed(input int n, input logic [TW-1:0] base);
    int fed = 0;
    bit acc;
    for (int c = 0; c < 200 && fed < n; c++) begin
      in_valid = 1'b1;
      in_tag = base + TW'(fed);
      acc = model_ready();
      step();
      if (acc) fed++;
    end
    in_valid = 1'b0;
    check_eq("feed_count", fed, n);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
    run(2);
    reset_n = 1'b1;
    start_log.delete();
  endtask

  initial begin
    int mark;
    for (int k = 0; k < N; k++) begin m_busy[k] = 1'b0; m_tag[k] = '0; timer[k] = 0; end

    // Reset values
    do_reset();
    check_eq("rst_idle", idle, 1'b1);
    check_eq("rst_core_tag", core_tag, 32'd0);
    check_eq("rst_match_tag", match_tag, 32'd0);
    check_eq("rst_match_core", match_core, 0);
    check_eq("rst_in_ready", in_ready, 1'b0);

    // Round-robin dispatch, tags 0..7, 10-cycle cores, no match
    lat_tab = '{10, 10, 10, 10}; mt_tab = '{0, 0, 0, 0};
    enable = 1'b1;
    feed(8, 32'd0);
    run(14);
    check_eq("rr_log_len", start_log.size(), 8);
    for (int i = 0; i < start_log.size() && i < 8; i++) check_eq("rr_order", start_log[i], i % 4);
    check_eq("rr_issued", issued_count, 32'd8);
    check_eq("rr_done", done_count, 32'd8);

    // First-match capture: tag 6 lands on core 2 and matches
    do_reset();
    lat_tab = '{8, 9, 5, 10}; mt_tab = '{0, 0, 1, 0};
    enable = 1'b1; step();
    feed(4, 32'd4);
    in_valid = 1'b1; in_tag = 32'd8;
    run(14);
    in_valid = 1'b0;
    check_eq("fm_valid", match_valid, 1'b1);
    check_eq("fm_tag", match_tag, 32'h0000_0006);
    check_eq("fm_core", match_core, 2);
    check_eq("fm_ready", in_ready, 1'b0);
    check_eq("fm_found_not_idle", idle, 1'b0);
    clear = 1'b1; step(); clear = 1'b0; enable = 1'b0;
    check_eq("fm_clear_idle", idle, 1'b1);
    check_eq("fm_clear_valid", match_valid, 1'b0);
    run(3);

    // Simultaneous matches on cores 1 and 3, later match on core 0
    do_reset();
    lat_tab = '{14, 8, 4, 6}; mt_tab = '{1, 1, 0, 1};
    enable = 1'b1; step();
    feed(4, 32'd10);
    run(16);
    check_eq("sm_core", match_core, 1);
    check_eq("sm_tag", match_tag, 32'd11);
    check_eq("sm_valid", match_valid, 1'b1);
    clear = 1'b1; enable = 1'b0; step(); clear = 1'b0;
    run(2);

    // Stop and drain with three cores occupied
    do_reset();
    lat_tab = '{6, 7, 8, 9}; mt_tab = '{0, 0, 0, 0};
    enable = 1'b1; step();
    feed(3, 32'd20);
    enable = 1'b0;
    mark = start_log.size();
    run(12);
    check_eq("sd_no_start", start_log.size(), mark);
    check_eq("sd_idle", idle, 1'b1);
    check_eq("sd_no_match", match_valid, 1'b0);

    // Stray done on an idle core, then issued_count wrap
    do_reset();
    lat_tab = '{5, 5, 5, 5}; mt_tab = '{0, 0, 0, 0};
    enable = 1'b1; run(2);
    extra_done = 4'b0010; extra_match = 4'b0010; step();
    extra_done = '0; extra_match = '0; step();
    check_eq("stray_done_cnt", done_count, 32'd1);
    check_eq("stray_no_match", match_valid, 1'b0);
    check_eq("stray_ready", in_ready, 1'b1);
    feed(1, 32'd30);
    check_eq("stray_grant0", start_log.size() > 0 ? start_log[0] : -1, 0);
    force dut.issued_r = 32'hFFFF_FFFF;
    #1;
    release dut.issued_r;
    m_issued = 32'hFFFF_FFFF;
    feed(1, 32'd31);
    check_eq("wrap_issued", issued_count, 32'd0);
    enable = 1'b0; run(8);

    // Reset mid-run with cores occupied
    do_reset();
    lat_tab = '{20, 20, 20, 20}; mt_tab = '{0, 0, 0, 0};
    enable = 1'b1; step();
    feed(3, 32'd40);
    reset_n = 1'b0; in_valid = 1'b1; in_tag = 32'd99;
    step();
    check_eq("mr_start", core_start, 4'b0000);
    check_eq("mr_idle", idle, 1'b1);
    check_eq("mr_issued", issued_count, 32'd0);
    check_eq("mr_done", done_count, 32'd0);
    check_eq("mr_core_tag", core_tag, 32'd0);
    check_eq("mr_match_valid", match_valid, 1'b0);
    reset_n = 1'b1;
    mark = start_log.size();
    feed(1, 32'h55);
    check_eq("mr_first_grant", start_log.size() > mark ? start_log[mark] : -1, 0);
    enable = 1'b0; run(25);

    // Randomized traffic with stray dones, clears, enable toggles and resets
    directed = 1'b0; stray_en = 1'b1; enable = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      clear = ($urandom_range(0, 14) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_tag = $urandom;
      reset_n = ($urandom_range(0, 399) != 0);
      step();
    end
    reset_n = 1'b1; clear = 1'b0; in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
